// File: rtl/ps2_event_queue_if.sv
// Byte-in / event-out bundle for the PS/2 event queue.
// master drives received bytes and consumes events; slave is the queue itself.
interface ps2_event_queue_if #(
    parameter int depthBits = 3
);
    logic [7:0]         rxData;
    logic               rxDataReady;
    logic               rxError;
    logic [9:0]         evData;
    logic               evValid;
    logic               evReady;
    logic               overflow;
    logic               clearOverflow;
    logic [depthBits:0] count;

    modport master (
        output rxData, rxDataReady, rxError, evReady, clearOverflow,
        input  evData, evValid, overflow, count
    );

    modport slave (
        input  rxData, rxDataReady, rxError, evReady, clearOverflow,
        output evData, evValid, overflow, count
    );
endinterface

// File: rtl/ps2_event_queue.sv
// Folds PS/2 scan-code prefixes (E0/F0/E1) into 10-bit key events and
// queues them in a show-ahead FIFO drained with valid/ready.
module ps2_event_queue #(
    parameter int depthBits     = 3,
    parameter int timeoutBits   = 20,
    parameter int timeoutCycles = 750000
) (
    input logic               clk,
    input logic               resetN,
    ps2_event_queue_if.slave  bus
);
    localparam int DEPTH = 2 ** depthBits;
    localparam logic [timeoutBits-1:0] TMO_LAST = timeoutBits'(timeoutCycles - 1);
    localparam logic [timeoutBits-1:0] TMO_ONE  = timeoutBits'(1);
    localparam logic [depthBits:0]     CNT_ONE  = (depthBits + 1)'(1);
    localparam logic [depthBits:0]     CNT_FULL = (depthBits + 1)'(DEPTH);
    localparam logic [depthBits-1:0]   PTR_ONE  = depthBits'(1);

    typedef enum logic [2:0] {IDLE, EXT, REL, EXTREL, PAUSE} state_t;

    state_t                 state, state_nxt;
    logic [2:0]             skip, skip_nxt;
    logic [timeoutBits-1:0] tmo, tmo_nxt;
    logic                   prev_ready;
    logic                   accept;
    logic                   push;
    logic [9:0]             push_data;

    logic [9:0]             mem [DEPTH];
    logic [depthBits-1:0]   rd_ptr, wr_ptr;
    logic [depthBits:0]     cnt;
    logic                   ovf;
    logic [9:0]             last_q;
    logic                   pop, full, do_push;

    // Rising edge of the receiver's level flag marks one new byte.
    assign accept = bus.rxDataReady & ~prev_ready & ~bus.rxError;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            skip       <= '0;
            tmo        <= '0;
            prev_ready <= 1'b0;
        end else begin
            state      <= state_nxt;
            skip       <= skip_nxt;
            tmo        <= tmo_nxt;
            prev_ready <= bus.rxDataReady;
        end
    end

    always_comb begin
        state_nxt = state;
        skip_nxt  = skip;
        tmo_nxt   = tmo;
        push      = 1'b0;
        push_data = '0;
        if (bus.rxError) begin
            state_nxt = IDLE;
            skip_nxt  = '0;
            tmo_nxt   = '0;
        end else if (accept) begin
            tmo_nxt = '0;
            unique case (state)
                IDLE: begin
                    if (bus.rxData == 8'hE0)      state_nxt = EXT;
                    else if (bus.rxData == 8'hF0) state_nxt = REL;
                    else if (bus.rxData == 8'hE1) begin
                        state_nxt = PAUSE;
                        skip_nxt  = 3'd7;
                    end else if (!(bus.rxData inside {8'h00, 8'hAA, 8'hEE, 8'hFA,
                                                      8'hFC, 8'hFE, 8'hFF})) begin
                        push      = 1'b1;
                        push_data = {2'b00, bus.rxData};
                    end
                end
                EXT: begin
                    if (bus.rxData == 8'hF0) state_nxt = EXTREL;
                    else if (bus.rxData != 8'hE0) begin
                        push      = 1'b1;
                        push_data = {2'b01, bus.rxData};
                        state_nxt = IDLE;
                    end
                end
                REL: begin
                    push      = 1'b1;
                    push_data = {2'b10, bus.rxData};
                    state_nxt = IDLE;
                end
                EXTREL: begin
                    push      = 1'b1;
                    push_data = {2'b11, bus.rxData};
                    state_nxt = IDLE;
                end
                PAUSE: begin
                    // Pause is a fixed 8-byte burst; its content carries no information.
                    if (skip == 3'd1) begin
                        push      = 1'b1;
                        push_data = 10'h177;
                        state_nxt = IDLE;
                        skip_nxt  = '0;
                    end else begin
                        skip_nxt = skip - 3'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state == IDLE) begin
            tmo_nxt = '0;
        end else if (tmo == TMO_LAST) begin
            state_nxt = IDLE;
            skip_nxt  = '0;
            tmo_nxt   = '0;
        end else begin
            tmo_nxt = tmo + TMO_ONE;
        end
    end

    assign pop     = (cnt != '0) & bus.evReady;
    assign full    = (cnt == CNT_FULL);
    assign do_push = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            last_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                last_q <= mem[rd_ptr];
            end
            unique case ({do_push, pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
            if (push & full & ~pop)    ovf <= 1'b1;
            else if (bus.clearOverflow) ovf <= 1'b0;
        end
    end

    // When empty, keep presenting the last popped event rather than stale storage.
    assign bus.evData   = (cnt != '0) ? mem[rd_ptr] : last_q;
    assign bus.evValid  = (cnt != '0);
    assign bus.count    = cnt;
    assign bus.overflow = ovf;
endmodule

// File: tb/tb_ps2_event_queue.sv
// Directed plus randomized bench for ps2_event_queue against a sequence-level
// reference model (prefix byte list + event queue).
module tb_ps2_event_queue;
    localparam int DB    = 3;
    localparam int DEPTH = 8;
    localparam int TC    = 40;

    logic clk    = 1'b0;
    logic resetN = 1'b0;
    int   total  = 0;
    int   passed = 0;

    ps2_event_queue_if #(.depthBits(DB)) bus ();

    ps2_event_queue #(.depthBits(DB), .timeoutBits(8), .timeoutCycles(TC)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [9:0] mq  [$];
    logic [7:0] pfx [$];
    bit         m_ovf;
    bit         m_prev;
    int         tcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic bit model_byte(input logic [7:0] b, output logic [9:0] ev);
        ev = '0;
        if (pfx.size() == 0) begin
            if (b inside {8'hE0, 8'hF0, 8'hE1}) begin
                pfx.push_back(b);
                return 1'b0;
            end
            if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF}) return 1'b0;
            ev = {2'b00, b};
            return 1'b1;
        end
        if (pfx[0] == 8'hE1) begin
            pfx.push_back(b);
            if (pfx.size() == 8) begin
                pfx.delete();
                ev = 10'h177;
                return 1'b1;
            end
            return 1'b0;
        end
        if (pfx.size() == 1 && pfx[0] == 8'hE0 && b == 8'hE0) return 1'b0;
        if (pfx.size() == 1 && pfx[0] == 8'hE0 && b == 8'hF0) begin
            pfx.push_back(b);
            return 1'b0;
        end
        ev = {pfx[pfx.size()-1] == 8'hF0, pfx[0] == 8'hE0, b};
        pfx.delete();
        return 1'b1;
    endfunction

    function automatic void model_reset();
        mq.delete();
        pfx.delete();
        m_ovf  = 1'b0;
        m_prev = 1'b0;
        tcnt   = 0;
    endfunction

    // One clock: drive at negedge, check outputs of the previous edge, advance model.
    task automatic cycle(input bit rdy, input bit lvl, input logic [7:0] d,
                         input bit err, input bit clr);
        bit pop, acc, has, full0, drop;
        logic [9:0] ev;
        bus.evReady       = rdy;
        bus.rxDataReady   = lvl;
        bus.rxData        = d;
        bus.rxError       = err;
        bus.clearOverflow = clr;
        chk("evValid", {31'd0, bus.evValid}, {31'd0, mq.size() != 0});
        chk("count", {28'd0, bus.count}, mq.size());
        chk("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
        if (mq.size() != 0) chk("evData", {22'd0, bus.evData}, {22'd0, mq[0]});
        full0  = (mq.size() == DEPTH);
        pop    = (mq.size() != 0) && rdy;
        acc    = lvl && !m_prev && !err;
        m_prev = lvl;
        has    = 1'b0;
        ev     = '0;
        if (err) begin
            pfx.delete();
            tcnt = 0;
        end else if (acc) begin
            tcnt = 0;
            has  = model_byte(d, ev);
        end else if (pfx.size() == 0) begin
            tcnt = 0;
        end else if (tcnt == TC - 1) begin
            pfx.delete();
            tcnt = 0;
        end else begin
            tcnt++;
        end
        if (pop) void'(mq.pop_front());
        drop = has && full0 && !pop;
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (has && !drop) mq.push_back(ev);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        cycle(1'b0, 1'b1, b, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, b, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(rdy, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] pause_seq [8];
        logic [7:0] junk [7];
        logic [7:0] b;
        int r;
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        junk      = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
        bus.rxData = '0; bus.rxDataReady = 1'b0; bus.rxError = 1'b0;
        bus.evReady = 1'b0; bus.clearOverflow = 1'b0;
        model_reset();

        @(negedge clk);
        chk("rst_evValid", {31'd0, bus.evValid}, 0);
        chk("rst_evData", {22'd0, bus.evData}, 0);
        chk("rst_count", {28'd0, bus.count}, 0);
        chk("rst_overflow", {31'd0, bus.overflow}, 0);
        resetN = 1'b1;
        @(negedge clk);

        send(8'h1C);
        chk("t1_data", {22'd0, bus.evData}, 32'h01C);
        chk("t1_count", {28'd0, bus.count}, 1);
        idle(2, 1'b1);

        send(8'hE0); send(8'hF0);
        chk("t2_prefix_none", {31'd0, bus.evValid}, 0);
        send(8'h75);
        chk("t2_extrel", {22'd0, bus.evData}, 32'h375);
        idle(2, 1'b1);
        send(8'hF0); send(8'h1C);
        chk("t2_rel", {22'd0, bus.evData}, 32'h21C);
        idle(2, 1'b1);

        foreach (pause_seq[i]) send(pause_seq[i]);
        chk("t3_count", {28'd0, bus.count}, 1);
        chk("t3_pause", {22'd0, bus.evData}, 32'h177);
        idle(2, 1'b1);
        send(8'h1C);
        chk("t3_after", {22'd0, bus.evData}, 32'h01C);
        idle(2, 1'b1);

        for (int i = 0; i < 9; i++) send(8'h15 + 8'(i));
        chk("t4_count", {28'd0, bus.count}, 8);
        chk("t4_ovf", {31'd0, bus.overflow}, 1);
        for (int i = 0; i < 8; i++) begin
            chk("t4_order", {22'd0, bus.evData}, 32'h015 + i);
            cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("t4_clear", {31'd0, bus.overflow}, 0);

        send(8'hF0);
        idle(TC + 2, 1'b0);
        send(8'h1C);
        chk("t5_timeout", {22'd0, bus.evData}, 32'h01C);
        idle(2, 1'b1);
        send(8'hE0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        send(8'h6B);
        chk("t5_rxerr", {22'd0, bus.evData}, 32'h06B);
        idle(2, 1'b1);

        for (int i = 0; i < 8; i++) send(8'h21 + 8'(i));
        chk("t6_full", {28'd0, bus.count}, 8);
        cycle(1'b1, 1'b1, 8'h30, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 8'h30, 1'b0, 1'b0);
        chk("t6_count", {28'd0, bus.count}, 8);
        chk("t6_ovf", {31'd0, bus.overflow}, 0);
        send(8'hE0);
        #2 resetN = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, bus.evValid}, 0);
        chk("t6_rst_count", {28'd0, bus.count}, 0);
        model_reset();
        @(negedge clk);
        resetN = 1'b1;
        send(8'h1C);
        chk("t6_post_rst", {22'd0, bus.evData}, 32'h01C);
        idle(2, 1'b1);

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = 8'hE1;
                3: b = junk[$urandom_range(0, 6)];
                default: b = 8'($urandom_range(1, 127));
            endcase
            cycle($urandom_range(0, 3) == 0, 1'b1, b,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0);
            cycle($urandom_range(0, 3) == 0, 1'b0, b, 1'b0, 1'b0);
            if ($urandom_range(0, 14) == 0) idle($urandom_range(0, TC + 5), $urandom_range(0, 1) == 1);
        end
        idle(12, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
